// File: rtl/rr_result_mux.sv
// rr_result_mux
//   Registered N-channel result selector feeding register-file writeback.
//   At most one producer is granted per cycle. The chosen result is held
//   in the output register until writeback accepts it. Arbitration is
//   round-robin (RR_EN=1) or fixed lowest-index priority (RR_EN=0). A
//   forced-select mode lets decode steer a single source directly.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [NCH]    per-channel request
//   in_data    [NCH*W]  packed channel data, channel i at [i*W +: W]
//   in_ready   [NCH]    per-channel accept, one-hot or zero
//   force_en            restrict the grant to channel force_sel
//   force_sel  [SW]     forced channel index (>= NCH means grant nothing)
//   out_valid           output register holds a result
//   out_data   [W]      selected data
//   out_sel    [SW]     index of the channel that produced out_data
//   out_ready           downstream accept
module rr_result_mux #(
  parameter int NCH   = 5,
  parameter int W     = 32,          // core XLEN
  parameter int SW    = $clog2(NCH),
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic             force_en,
  input  logic [SW-1:0]    force_sel,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  logic [SW-1:0]  ptr;       // first channel to consider in round-robin mode
  logic [NCH-1:0] elig;      // requests allowed to compete this cycle
  logic [NCH-1:0] gnt;       // one-hot grant
  logic [SW-1:0]  gnt_idx;   // binary index of gnt
  logic [W-1:0]   gnt_data;  // data of the granted channel
  logic           load;      // output register may take a new result

  // The register can load when empty or when its current result drains
  // in this same cycle, which gives one result per cycle under full flow.
  assign load = !out_valid || out_ready;

  // Eligible set. An out-of-range forced index masks every channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    elig = '0;
    if (!force_en) begin
      elig = in_valid;
    end else if ({1'b0, force_sel} < (SW+1)'(NCH)) begin
      elig = in_valid & (NCH'(1) << force_sel);
    end
  end

  // Grant search. Candidate k is ptr+k with explicit wrap, so non-power-of-two
  // channel counts never index past NCH-1. In fixed-priority mode the scan
  // simply starts at channel 0.
  always_comb begin
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      sum = RR_EN ? ({1'b0, ptr} + (SW+1)'(k)) : (SW+1)'(k);
      if (sum >= (SW+1)'(NCH)) sum = sum - (SW+1)'(NCH);
      idx = sum[SW-1:0];
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  // One-hot AND-OR data mux.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      gnt_data = gnt_data | (gnt[i] ? in_data[i*W +: W] : '0);
    end
  end

  // Nothing is accepted while reset is held, even though the empty output
  // register would otherwise allow a load.
  assign in_ready = (load && rst_n) ? gnt : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: reset is asynchronous and clears the held result so no partial
  // transfer survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (|gnt) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
        if (RR_EN) begin
          ptr <= (gnt_idx == SW'(NCH-1)) ? '0 : gnt_idx + SW'(1);
        end
      end else begin
        // Nothing granted: drop valid, keep last data/sel and pointer.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_result_mux.sv
module tb_rr_result_mux;

  localparam int NCH = 5;
  localparam int W   = 32;
  localparam int SW  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic             force_en;
  logic [SW-1:0]    force_sel;
  logic             out_ready;
  logic [W-1:0]     d [NCH];

  logic [NCH-1:0]   in_ready,  fp_in_ready;
  logic             out_valid, fp_out_valid;
  logic [W-1:0]     out_data,  fp_out_data;
  logic [SW-1:0]    out_sel,   fp_out_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = d[i];
  end

  rr_result_mux #(.NCH(NCH), .W(W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_result_mux #(.NCH(NCH), .W(W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_valid(fp_out_valid), .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_ready(out_ready)
  );

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 5'b11111;
    force_en  = 1'b0;
    force_sel = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) d[i] = 32'h100 + i;
    #2;
    checks++; if (in_ready !== 5'b00000) begin failures++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 5'b00000); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    in_valid = '0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    checks++; if (dut.ptr !== 3'd0) begin failures++; $display("FAIL idle_ptr got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_single();
    d[2]      = 32'hDEADBEEF;
    in_valid  = 5'b00100;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 5'b00100) begin failures++; $display("FAIL single_in_ready got=%b exp=%b", in_ready, 5'b00100); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_out_data got=%h exp=deadbeef", out_data); end
    checks++; if (out_sel !== 3'd2) begin failures++; $display("FAIL single_out_sel got=%0d exp=2", out_sel); end
    checks++; if (dut.ptr !== 3'd3) begin failures++; $display("FAIL single_ptr got=%0d exp=3", dut.ptr); end
    in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold_data got=%h exp=deadbeef", out_data); end
  endtask

  task automatic test_mid_reset();
    d[0]      = 32'hAAAA0000;
    in_valid  = 5'b00001;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 5'b11111;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", out_data); end
    checks++; if (out_sel !== 3'd0) begin failures++; $display("FAIL midrst_sel got=%0d exp=0", out_sel); end
    checks++; if (dut.ptr !== 3'd0) begin failures++; $display("FAIL midrst_ptr got=%0d exp=0", dut.ptr); end
    checks++; if (in_ready !== 5'b00000) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_sel [7];
    exp_sel = '{0, 1, 2, 3, 4, 0, 1};
    for (int i = 0; i < NCH; i++) d[i] = 32'hC0 + i;
    out_ready = 1'b1;
    in_valid  = 5'b11111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (out_sel !== SW'(exp_sel[c])) begin failures++; $display("FAIL rr_sel cycle=%0d got=%0d exp=%0d", c, out_sel, exp_sel[c]); end
      checks++; if (out_data !== 32'hC0 + exp_sel[c]) begin failures++; $display("FAIL rr_data cycle=%0d got=%h exp=%h", c, out_data, 32'hC0 + exp_sel[c]); end
      checks++; if (fp_out_sel !== 3'd0) begin failures++; $display("FAIL fp_sel cycle=%0d got=%0d exp=0", c, fp_out_sel); end
    end
    in_valid = '0;
    @(negedge clk);
    checks++; if (dut.ptr !== 3'd2) begin failures++; $display("FAIL rr_ptr got=%0d exp=2", dut.ptr); end
  endtask

  task automatic test_backpressure();
    d[0] = 32'hB0;
    d[1] = 32'hB1;
    d[2] = 32'h1;
    in_valid  = 5'b00100;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_data !== 32'h1) begin failures++; $display("FAIL bp_load got=%h exp=1", out_data); end
    out_ready = 1'b0;
    in_valid  = 5'b00011;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 5'b00000) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
      @(negedge clk);
      checks++; if (out_data !== 32'h1 || out_valid !== 1'b1 || out_sel !== 3'd2) begin failures++; $display("FAIL bp_hold cycle=%0d got=%h/%b/%0d exp=1/1/2", c, out_data, out_valid, out_sel); end
    end
    out_ready = 1'b1;
    #1;
    // ptr=3 with requests on 0 and 1: the scan wraps to channel 0
    checks++; if (in_ready !== 5'b00001) begin failures++; $display("FAIL bp_release_ready got=%b exp=%b", in_ready, 5'b00001); end
    @(negedge clk);
    checks++; if (out_sel !== 3'd0 || out_data !== 32'hB0) begin failures++; $display("FAIL bp_release_out got=%0d/%h exp=0/b0", out_sel, out_data); end
    in_valid = 5'b00010;
    #1;
    checks++; if (in_ready !== 5'b00010) begin failures++; $display("FAIL bp_next_ready got=%b exp=%b", in_ready, 5'b00010); end
    @(negedge clk);
    checks++; if (out_sel !== 3'd1 || out_data !== 32'hB1) begin failures++; $display("FAIL bp_next_out got=%0d/%h exp=1/b1", out_sel, out_data); end
    in_valid = '0;
    @(negedge clk);
    checks++; if (dut.ptr !== 3'd2) begin failures++; $display("FAIL bp_ptr got=%0d exp=2", dut.ptr); end
  endtask

  task automatic test_force();
    d[4]      = 32'hF4;
    force_en  = 1'b1;
    force_sel = 3'd4;
    in_valid  = 5'b10001;
    #1;
    checks++; if (in_ready !== 5'b10000) begin failures++; $display("FAIL force_ready got=%b exp=%b", in_ready, 5'b10000); end
    checks++; if (fp_in_ready !== 5'b10000) begin failures++; $display("FAIL force_fp_ready got=%b exp=%b", fp_in_ready, 5'b10000); end
    @(negedge clk);
    checks++; if (out_sel !== 3'd4 || out_data !== 32'hF4) begin failures++; $display("FAIL force_out got=%0d/%h exp=4/f4", out_sel, out_data); end
    checks++; if (dut.ptr !== 3'd0) begin failures++; $display("FAIL force_ptr got=%0d exp=0", dut.ptr); end
    force_sel = 3'd5;
    in_valid  = 5'b11111;
    #1;
    checks++; if (in_ready !== 5'b00000) begin failures++; $display("FAIL force_oor_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL force_oor_valid got=%b exp=0", out_valid); end
    checks++; if (dut.ptr !== 3'd0) begin failures++; $display("FAIL force_oor_ptr got=%0d exp=0", dut.ptr); end
    checks++; if (out_sel !== 3'd4) begin failures++; $display("FAIL force_oor_sel got=%0d exp=4", out_sel); end
    force_en = 1'b0;
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    d[1] = 32'hA1;
    d[3] = 32'hA3;
    in_valid = 5'b01000;
    @(negedge clk);
    checks++; if (dut.ptr !== 3'd4) begin failures++; $display("FAIL wrap_setup_ptr got=%0d exp=4", dut.ptr); end
    in_valid = 5'b00010;
    #1;
    checks++; if (in_ready !== 5'b00010) begin failures++; $display("FAIL wrap_ready got=%b exp=%b", in_ready, 5'b00010); end
    @(negedge clk);
    checks++; if (out_sel !== 3'd1 || out_data !== 32'hA1) begin failures++; $display("FAIL wrap_out got=%0d/%h exp=1/a1", out_sel, out_data); end
    checks++; if (dut.ptr !== 3'd2) begin failures++; $display("FAIL wrap_ptr got=%0d exp=2", dut.ptr); end
    in_valid = '0;
    @(negedge clk);
    checks++; if (dut.ptr !== 3'd2) begin failures++; $display("FAIL idle_ptr_hold got=%0d exp=2", dut.ptr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'hA1) begin failures++; $display("FAIL idle_data_hold got=%h exp=a1", out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mid_reset();
    test_round_robin();
    test_backpressure();
    test_force();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_result_mux.md
Name: rr_result_mux

Overview:
- Registered, N-channel, round-robin result selector with valid/ready handshakes per input channel and on the output.
- Generalised successor of the fixed five-way combinational result mux.
- Sits between the execution units (ALU, load unit, CSR, multiplier, PC+4 path) and register-file writeback. Selects at most one producer per cycle and holds the result stable until writeback accepts it.
- Adds a forced-select mode so decode can still steer a single source directly, matching the existing mux behaviour.

Parameters:
- NCH, 5, number of input channels (2..16).
- W, XLEN (riscv_pkg), data width of each channel and of the output.
- SW, $clog2(NCH), width of the channel index.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NCH  per-channel request.
- in_data  input  NCH*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  NCH  per-channel accept, one-hot or zero.
- force_en  input  1  when high, only channel force_sel may be granted.
- force_sel  input  SW  forced channel index.
- out_valid  output  1  output register holds a result.
- out_data  output  W  selected data.
- out_sel  output  SW  index of the channel that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync-released by the system): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready=0 while rst_n is low.
- Reset asserted mid-transfer drops the held result. No partial state survives.
- Load condition: load = !out_valid || out_ready. The output register accepts a new grant only when load is 1.
- Eligible set E:
  - force_en=0: E = in_valid.
  - force_en=1 and force_sel<NCH: E = in_valid & (1<<force_sel).
  - force_en=1 and force_sel>=NCH: E = 0. No grant is made and nothing is flagged; this replaces the old 'x default.
- Grant, combinational, one-hot g:
  - RR_EN=1: first set bit of E scanning ptr, ptr+1, … NCH-1, 0, … ptr-1 (wrap-around).
  - RR_EN=0: lowest set bit of E.
- in_ready = load ? g : 0. A channel transfers on in_valid[i] & in_ready[i].
- On a cycle where load=1 and g≠0, at the next edge: out_valid←1, out_data←in_data[grant], out_sel←grant index.
- RR_EN=1: ptr←(grant+1) mod NCH in the same cycle. ptr is unchanged when nothing is granted.
- On a cycle where load=1 and g=0: out_valid←0; out_data and out_sel hold their previous values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid are held stable and in_ready=0.
- Latency is one cycle from input handshake to out_valid.
- Throughput is one result per cycle with out_ready held high (simultaneous output drain and new load in the same cycle).
- Inputs must hold in_valid/in_data until accepted. The block does not require this, but a non-granted channel is never consumed.
- ptr width is SW. For non-power-of-two NCH the wrap is explicit; ptr never takes a value ≥NCH.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-stream with out_valid=1.
  - Response: out_valid, out_data and out_sel go to 0 immediately. in_ready=0. After release with no requests, out_valid stays 0.
- Single channel, NCH=5, W=32:
  - Stimulus: in_valid=5'b00100, data[2]=32'hDEADBEEF, out_ready=1.
  - Response: in_ready=5'b00100. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=2. ptr=3.
- Round-robin fairness:
  - Stimulus: in_valid=5'b11111 held for 7 cycles, out_ready=1, ptr=0.
  - Response: out_sel sequence 0,1,2,3,4,0,1.
  - Same stimulus with RR_EN=0: out_sel is 0 every cycle.
- Backpressure:
  - Stimulus: out_valid=1 with data 32'h1, out_ready=0 for 3 cycles, in_valid=5'b00011.
  - Response: out_data stays 32'h1 and in_ready=0 for all 3 cycles.
  - Then raise out_ready: the same cycle grants the next channel per ptr; the new data appears one cycle later.
- Forced select:
  - Stimulus: force_en=1, force_sel=4, in_valid=5'b10001.
  - Response: in_ready=5'b10000, out_sel=4.
  - force_sel=5 with in_valid=5'b11111: in_ready=0, out_valid falls to 0 and ptr is unchanged.
- Wrap-around and idle ptr:
  - Stimulus: ptr=4, in_valid=5'b00010.
  - Response: grant 1, ptr→2.
  - Idle cycle (in_valid=0): ptr stays 2, out_valid→0, out_data holds its value.
